pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL: CLK  input  1  clock, all state updates on rising edge.
REQ-002 SHALL: RSTN  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: IMEM_READY  input  1  instruction memory returns valid word this cycle.
REQ-004 SHALL: DMEM_BUSY  input  1  data memory cannot accept/complete MEM-stage access.
REQ-005 SHALL: ID_VALID  input  1  ID stage holds a real instruction.
REQ-006 SHALL: ID_RS1, ID_RS2  input  5 each  source registers read by ID instruction.
REQ-007 SHALL: ID_RS1_USE, ID_RS2_USE  input  1 each  source actually read.
REQ-008 SHALL: EX_RD  input  5, EX_WE  input  1, EX_IS_LOAD  input  1  EX-stage destination info.
REQ-009 SHALL: MEM_RD  input  5, MEM_WE  input  1  MEM-stage destination info.
REQ-010 SHALL: BR_TAKEN  input  1  EX resolved a taken BR/BRL/J/JL.
REQ-011 SHALL: IF_EN, ID_EN  output  1 each  PC/IF-ID and ID-EX register enables.
REQ-012 SHALL: ID_FLUSH  output  1  invalidate IF-ID contents; EX_BUBBLE  output  1  insert NOP into EX.
REQ-013 SHALL: IREQ  output  1  instruction fetch request.
REQ-014 SHALL: FWD_A, FWD_B  output  2 each  operand source: 00 regfile, 01 EX result, 10 MEM result.
REQ-015 SHALL: STATE  output  3  current FSM state; STALL_CNT  output  16  stall cycle counter.

Function
REQ-016 SHALL: FSM states IDLE, RUN, LDSTALL, MEMWAIT, FLUSH; outputs Mealy from registered state plus current inputs.
REQ-017 SHALL: IDLE: all enables, ID_FLUSH, EX_BUBBLE, IREQ = 0; next state RUN unconditionally.
REQ-018 SHALL: RUN priority: BR_TAKEN > DMEM_BUSY > load-use hazard > !IMEM_READY.
REQ-019 SHALL: RUN + BR_TAKEN: IF_EN=1, ID_EN=1, ID_FLUSH=1, EX_BUBBLE=1; next FLUSH.
REQ-020 SHALL: RUN + DMEM_BUSY (no branch): IF_EN=ID_EN=0, EX_BUBBLE=0; next MEMWAIT.
REQ-021 SHALL: load-use hazard = ID_VALID & EX_IS_LOAD & EX_WE & EX_RD!=0 & ((ID_RS1_USE & ID_RS1==EX_RD) | (ID_RS2_USE & ID_RS2==EX_RD)).
REQ-022 SHALL: RUN + hazard: IF_EN=ID_EN=0, EX_BUBBLE=1; next LDSTALL.
REQ-023 SHALL: RUN + !IMEM_READY: IF_EN=ID_EN=0, EX_BUBBLE=1, IREQ held 1; stay RUN.
REQ-024 SHALL: RUN otherwise: IF_EN=ID_EN=IREQ=1, flush/bubble 0.
REQ-025 SHALL: LDSTALL lasts exactly 1 cycle: enables = IMEM_READY, EX_BUBBLE=0; next RUN; DMEM_BUSY here goes to MEMWAIT.
REQ-026 SHALL: MEMWAIT: whole pipe frozen (enables 0, EX_BUBBLE 0, IREQ 0); BR_TAKEN ignored; exit to RUN on first cycle DMEM_BUSY=0.
REQ-027 SHALL: FLUSH lasts 1 cycle: ID_FLUSH=1, IF_EN=ID_EN=1, IREQ=1; BR_TAKEN ignored (EX holds bubble); next RUN.
REQ-028 SHALL: FWD_A: 01 if EX_WE & EX_RD!=0 & EX_RD==ID_RS1 & !EX_IS_LOAD; else 10 if MEM_WE & MEM_RD!=0 & MEM_RD==ID_RS1; else 00; FWD_B same with ID_RS2.
REQ-029 SHALL: FWD_A/FWD_B forced 00 when ID_VALID=0 or corresponding _USE=0; zero-cycle latency.
REQ-030 SHALL: register 0 never a hazard or forwarding source.
REQ-031 SHALL: STALL_CNT increments each cycle IF_EN=0 outside IDLE; saturates at 16'hFFFF, no wrap.

Reset
REQ-032 SHALL: RSTN low asynchronously forces STATE=IDLE, STALL_CNT=0, all outputs 0 including FWD_A/FWD_B=00.
REQ-033 SHALL: reset mid-stall/mid-flush discards state; first post-reset cycle is IDLE, second RUN.

Structure
REQ-034 SHALL: package pipe_ctrl_pkg holds state encoding (IDLE=0, RUN=1, LDSTALL=2, MEMWAIT=3, FLUSH=4) and FWD codes.
REQ-035 SHALL: combinational compare logic (REQ-021, REQ-028..030) in sub-module hazard_fwd_unit; FSM and counter in pipe_ctrl.

Verification
REQ-036 SHALL: EX_RD=3,EX_WE=1,EX_IS_LOAD=1, ID_RS1=3 used -> 1 cycle IF_EN=0,EX_BUBBLE=1, then LDSTALL, FWD_A=10, STALL_CNT=1.
REQ-037 SHALL: EX_RD=5 non-load and MEM_RD=5 both writing, ID_RS2=5 -> FWD_B=01; EX_RD=0 -> FWD_B=00 regardless.
REQ-038 SHALL: BR_TAKEN in RUN -> ID_FLUSH=1 two consecutive cycles (RUN, FLUSH), second BR_TAKEN in FLUSH ignored.
REQ-039 SHALL: DMEM_BUSY high 4 cycles plus simultaneous load-use hazard -> MEMWAIT 4 cycles, no bubble, then hazard handled, STALL_CNT=5.
REQ-040 SHALL: RSTN pulsed low during MEMWAIT -> immediate IDLE, all outputs 0, STALL_CNT=0; saturation test preloads 0xFFFE, 3 stalls -> 0xFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : State encoding, forwarding codes and register-match helper
//            shared by the pipeline controller and its hazard/forward unit.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  typedef logic [2:0] state_t;
  typedef logic [1:0] fwd_t;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_RUN     = 3'd1;
  localparam logic [2:0] c_LDSTALL = 3'd2;
  localparam logic [2:0] c_MEMWAIT = 3'd3;
  localparam logic [2:0] c_FLUSH   = 3'd4;

  localparam logic [1:0] c_FWD_RF  = 2'b00;
  localparam logic [1:0] c_FWD_EX  = 2'b01;
  localparam logic [1:0] c_FWD_MEM = 2'b10;

  // r0 is hardwired zero, so it can never be a producer.
  function automatic logic reg_match(input logic [4:0] rd, input logic we,
                                     input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Brief    : Pipeline status inputs and control outputs of pipe_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic       IMEM_READY;
  logic       DMEM_BUSY;
  logic       ID_VALID;
  logic [4:0] ID_RS1;
  logic [4:0] ID_RS2;
  logic       ID_RS1_USE;
  logic       ID_RS2_USE;
  logic [4:0] EX_RD;
  logic       EX_WE;
  logic       EX_IS_LOAD;
  logic [4:0] MEM_RD;
  logic       MEM_WE;
  logic       BR_TAKEN;

  logic        IF_EN;
  logic        ID_EN;
  logic        ID_FLUSH;
  logic        EX_BUBBLE;
  logic        IREQ;
  fwd_t        FWD_A;
  fwd_t        FWD_B;
  state_t      STATE;
  logic [15:0] STALL_CNT;

  modport master (
    output IMEM_READY, DMEM_BUSY, ID_VALID, ID_RS1, ID_RS2, ID_RS1_USE,
           ID_RS2_USE, EX_RD, EX_WE, EX_IS_LOAD, MEM_RD, MEM_WE, BR_TAKEN,
    input  IF_EN, ID_EN, ID_FLUSH, EX_BUBBLE, IREQ, FWD_A, FWD_B, STATE,
           STALL_CNT
  );

  modport slave (
    input  IMEM_READY, DMEM_BUSY, ID_VALID, ID_RS1, ID_RS2, ID_RS1_USE,
           ID_RS2_USE, EX_RD, EX_WE, EX_IS_LOAD, MEM_RD, MEM_WE, BR_TAKEN,
    output IF_EN, ID_EN, ID_FLUSH, EX_BUBBLE, IREQ, FWD_A, FWD_B, STATE,
           STALL_CNT
  );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_unit
// Brief    : Combinational load-use detection and operand forwarding select.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_use,
  input  logic       id_rs2_use,
  input  logic [4:0] ex_rd,
  input  logic       ex_we,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_we,
  output logic       load_use,
  output fwd_t       fwd_a,
  output fwd_t       fwd_b
);

  logic w_rs1_live;
  logic w_rs2_live;
  logic w_ex_rs1;
  logic w_ex_rs2;
  logic w_mem_rs1;
  logic w_mem_rs2;

  assign w_rs1_live = id_valid & id_rs1_use;
  assign w_rs2_live = id_valid & id_rs2_use;

  assign w_ex_rs1  = reg_match(ex_rd,  ex_we,  id_rs1);
  assign w_ex_rs2  = reg_match(ex_rd,  ex_we,  id_rs2);
  assign w_mem_rs1 = reg_match(mem_rd, mem_we, id_rs1);
  assign w_mem_rs2 = reg_match(mem_rd, mem_we, id_rs2);

  assign load_use = ex_is_load & ((w_rs1_live & w_ex_rs1) | (w_rs2_live & w_ex_rs2));

  // A load's data is not ready in EX, so it may only forward once it is in MEM.
  always_comb begin
    fwd_a = c_FWD_RF;
    if (w_rs1_live) begin
      if (w_ex_rs1 && !ex_is_load) fwd_a = c_FWD_EX;
      else if (w_mem_rs1)          fwd_a = c_FWD_MEM;
    end
  end

  always_comb begin
    fwd_b = c_FWD_RF;
    if (w_rs2_live) begin
      if (w_ex_rs2 && !ex_is_load) fwd_b = c_FWD_EX;
      else if (w_mem_rs2)          fwd_b = c_FWD_MEM;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Five-state pipeline controller (stall/flush/freeze) with a
//            saturating stall counter and operand forwarding select.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic CLK,
  input  logic RSTN,
  pipe_ctrl_if.slave bus
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_stall_cnt;
  logic        w_load_use;
  fwd_t        w_fwd_a;
  fwd_t        w_fwd_b;
  logic        w_if_en;
  logic        w_id_en;
  logic        w_id_flush;
  logic        w_ex_bubble;
  logic        w_ireq;

  hazard_fwd_unit u_hazard_fwd (
    .id_valid   (bus.ID_VALID),
    .id_rs1     (bus.ID_RS1),
    .id_rs2     (bus.ID_RS2),
    .id_rs1_use (bus.ID_RS1_USE),
    .id_rs2_use (bus.ID_RS2_USE),
    .ex_rd      (bus.EX_RD),
    .ex_we      (bus.EX_WE),
    .ex_is_load (bus.EX_IS_LOAD),
    .mem_rd     (bus.MEM_RD),
    .mem_we     (bus.MEM_WE),
    .load_use   (w_load_use),
    .fwd_a      (w_fwd_a),
    .fwd_b      (w_fwd_b)
  );

  always_comb begin
    w_next      = r_state;
    w_if_en     = 1'b0;
    w_id_en     = 1'b0;
    w_id_flush  = 1'b0;
    w_ex_bubble = 1'b0;
    w_ireq      = 1'b0;
    case (r_state)
      c_IDLE: w_next = c_RUN;
      c_RUN: begin
        if (bus.BR_TAKEN) begin
          w_if_en     = 1'b1;
          w_id_en     = 1'b1;
          w_id_flush  = 1'b1;
          w_ex_bubble = 1'b1;
          w_ireq      = 1'b1;
          w_next      = c_FLUSH;
        end else if (bus.DMEM_BUSY) begin
          w_next = c_MEMWAIT;
        end else if (w_load_use) begin
          w_ex_bubble = 1'b1;
          w_next      = c_LDSTALL;
        end else if (!bus.IMEM_READY) begin
          // Keep the fetch outstanding while the front end waits.
          w_ex_bubble = 1'b1;
          w_ireq      = 1'b1;
        end else begin
          w_if_en = 1'b1;
          w_id_en = 1'b1;
          w_ireq  = 1'b1;
        end
      end
      c_LDSTALL: begin
        if (bus.DMEM_BUSY) begin
          w_next = c_MEMWAIT;
        end else begin
          w_if_en = bus.IMEM_READY;
          w_id_en = bus.IMEM_READY;
          w_ireq  = 1'b1;
          w_next  = c_RUN;
        end
      end
      c_MEMWAIT: begin
        if (!bus.DMEM_BUSY) w_next = c_RUN;
      end
      c_FLUSH: begin
        // The branch in EX has been replaced by a bubble, so BR_TAKEN is stale.
        w_if_en    = 1'b1;
        w_id_en    = 1'b1;
        w_id_flush = 1'b1;
        w_ireq     = 1'b1;
        w_next     = c_RUN;
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= c_IDLE;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state <= w_next;
      if ((r_state != c_IDLE) && !w_if_en && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.IF_EN     = w_if_en;
  assign bus.ID_EN     = w_id_en;
  assign bus.ID_FLUSH  = w_id_flush;
  assign bus.EX_BUBBLE = w_ex_bubble;
  assign bus.IREQ      = w_ireq;
  // Forwarding is purely combinational, so it is masked while reset is held.
  assign bus.FWD_A     = RSTN ? w_fwd_a : c_FWD_RF;
  assign bus.FWD_B     = RSTN ? w_fwd_b : c_FWD_RF;
  assign bus.STATE     = r_state;
  assign bus.STALL_CNT = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// Self-checking bench for pipe_ctrl: behavioural reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pipe_ctrl;

  logic CLK = 1'b0;
  logic RSTN;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_ctrl_if bus();

  pipe_ctrl dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  localparam int S_IDLE = 0, S_RUN = 1, S_LDSTALL = 2, S_MEMWAIT = 3, S_FLUSH = 4;

  int          m_state  = S_IDLE;
  int          m_nstate = S_IDLE;
  int unsigned m_cnt    = 0;
  int unsigned m_ncnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Operand source chosen purely from the producer rules.
  function automatic int exp_fwd(input logic [4:0] rs, input logic use_it);
    if (!RSTN || !bus.ID_VALID || !use_it || rs == 5'd0) return 0;
    if (bus.EX_WE && bus.EX_RD == rs && !bus.EX_IS_LOAD) return 1;
    if (bus.MEM_WE && bus.MEM_RD == rs) return 2;
    return 0;
  endfunction

  function automatic bit exp_hazard();
    if (!(bus.ID_VALID && bus.EX_IS_LOAD && bus.EX_WE) || bus.EX_RD == 5'd0) return 0;
    return (bus.ID_RS1_USE && bus.ID_RS1 == bus.EX_RD) ||
           (bus.ID_RS2_USE && bus.ID_RS2 == bus.EX_RD);
  endfunction

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_state <= S_IDLE;
      m_cnt   <= 0;
    end else begin
      m_state <= m_nstate;
      m_cnt   <= m_ncnt;
    end
  end

  // e = {IF_EN, ID_EN, ID_FLUSH, EX_BUBBLE, IREQ}
  initial begin : compare
    logic [4:0] e;
    forever begin
      @(negedge CLK);
      e = 5'b00000;
      if (!RSTN) begin
        m_nstate = S_IDLE;
        m_ncnt   = 0;
      end else begin
        m_nstate = m_state;
        case (m_state)
          S_IDLE: m_nstate = S_RUN;
          S_RUN: begin
            if (bus.BR_TAKEN)            begin e = 5'b11111; m_nstate = S_FLUSH;   end
            else if (bus.DMEM_BUSY)      begin e = 5'b00000; m_nstate = S_MEMWAIT; end
            else if (exp_hazard())       begin e = 5'b00010; m_nstate = S_LDSTALL; end
            else if (!bus.IMEM_READY)          e = 5'b00011;
            else                               e = 5'b11001;
          end
          S_LDSTALL: begin
            if (bus.DMEM_BUSY) m_nstate = S_MEMWAIT;
            else begin
              e = {bus.IMEM_READY, bus.IMEM_READY, 3'b001};
              m_nstate = S_RUN;
            end
          end
          S_MEMWAIT: if (!bus.DMEM_BUSY) m_nstate = S_RUN;
          S_FLUSH: begin e = 5'b11101; m_nstate = S_RUN; end
          default: begin e = 5'b11101; m_nstate = S_RUN; end
        endcase
        m_ncnt = m_cnt;
        if (m_state != S_IDLE && !e[4] && m_cnt < 32'hFFFF) m_ncnt = m_cnt + 1;
      end
      chk("STATE",     bus.STATE,     m_state);
      chk("STALL_CNT", bus.STALL_CNT, m_cnt);
      chk("IF_EN",     bus.IF_EN,     e[4]);
      chk("ID_EN",     bus.ID_EN,     e[3]);
      chk("ID_FLUSH",  bus.ID_FLUSH,  e[2]);
      chk("EX_BUBBLE", bus.EX_BUBBLE, e[1]);
      chk("IREQ",      bus.IREQ,      e[0]);
      chk("FWD_A",     bus.FWD_A,     exp_fwd(bus.ID_RS1, bus.ID_RS1_USE));
      chk("FWD_B",     bus.FWD_B,     exp_fwd(bus.ID_RS2, bus.ID_RS2_USE));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    bus.IMEM_READY = 1'b1;  bus.DMEM_BUSY  = 1'b0;  bus.ID_VALID = 1'b0;
    bus.ID_RS1     = 5'd0;  bus.ID_RS2     = 5'd0;
    bus.ID_RS1_USE = 1'b0;  bus.ID_RS2_USE = 1'b0;
    bus.EX_RD      = 5'd0;  bus.EX_WE      = 1'b0;  bus.EX_IS_LOAD = 1'b0;
    bus.MEM_RD     = 5'd0;  bus.MEM_WE     = 1'b0;  bus.BR_TAKEN   = 1'b0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Ends at the start of the first RUN cycle after reset, inputs idle.
  task automatic do_reset();
    RSTN = 1'b0;
    set_idle();
    cyc();
    cyc();
    RSTN = 1'b1;
    cyc();
  endtask

  task automatic set_load_use_rs1_3();
    bus.ID_VALID = 1'b1; bus.ID_RS1 = 5'd3; bus.ID_RS1_USE = 1'b1;
    bus.EX_RD = 5'd3; bus.EX_WE = 1'b1; bus.EX_IS_LOAD = 1'b1;
  endtask

  initial begin : stim
    // Reset state, with forwarding inputs that would otherwise select EX.
    RSTN = 1'b0;
    set_idle();
    bus.ID_VALID = 1'b1; bus.ID_RS1 = 5'd7; bus.ID_RS1_USE = 1'b1;
    bus.EX_RD = 5'd7; bus.EX_WE = 1'b1;
    #3;
    chk("L_rst_state", bus.STATE, 0);
    chk("L_rst_cnt",   bus.STALL_CNT, 0);
    chk("L_rst_fwda",  bus.FWD_A, 0);
    chk("L_rst_ifen",  bus.IF_EN, 0);
    chk("L_rst_ireq",  bus.IREQ, 0);
    cyc(); cyc();
    set_idle();
    RSTN = 1'b1;
    #3;
    chk("L_post_idle", bus.STATE, 0);
    cyc(); #3;
    chk("L_post_run",  bus.STATE, 1);
    chk("L_run_ifen",  bus.IF_EN, 1);
    chk("L_run_ireq",  bus.IREQ, 1);

    // Load-use on rs1: one bubble cycle, then LDSTALL with MEM forwarding.
    do_reset();
    set_load_use_rs1_3();
    #3;
    chk("L_lu_ifen",   bus.IF_EN, 0);
    chk("L_lu_bubble", bus.EX_BUBBLE, 1);
    chk("L_lu_fwda",   bus.FWD_A, 0);
    cyc();
    set_idle();
    bus.ID_VALID = 1'b1; bus.ID_RS1 = 5'd3; bus.ID_RS1_USE = 1'b1;
    bus.MEM_RD = 5'd3; bus.MEM_WE = 1'b1;
    #3;
    chk("L_lu_state2", bus.STATE, 2);
    chk("L_lu_fwda2",  bus.FWD_A, 2);
    chk("L_lu_cnt",    bus.STALL_CNT, 1);
    chk("L_lu_ifen2",  bus.IF_EN, 1);
    cyc(); set_idle(); #3;
    chk("L_lu_back",   bus.STATE, 1);

    // Instruction memory not ready: hold fetch request, stay in RUN.
    cyc(); set_idle(); bus.IMEM_READY = 1'b0; #3;
    chk("L_im_ifen",   bus.IF_EN, 0);
    chk("L_im_ireq",   bus.IREQ, 1);
    chk("L_im_bubble", bus.EX_BUBBLE, 1);
    cyc(); set_idle(); #3;
    chk("L_im_state",  bus.STATE, 1);
    chk("L_im_cnt",    bus.STALL_CNT, 2);

    // Forwarding priority and r0 exclusion on rs2.
    cyc(); set_idle();
    bus.ID_VALID = 1'b1; bus.ID_RS2 = 5'd5; bus.ID_RS2_USE = 1'b1;
    bus.EX_RD = 5'd5; bus.EX_WE = 1'b1; bus.MEM_RD = 5'd5; bus.MEM_WE = 1'b1;
    #3;
    chk("L_fw_ex",     bus.FWD_B, 1);
    cyc();
    bus.ID_RS2 = 5'd0; bus.EX_RD = 5'd0;
    #3;
    chk("L_fw_r0",     bus.FWD_B, 0);
    cyc();
    bus.ID_RS2 = 5'd5; bus.EX_RD = 5'd5; bus.EX_IS_LOAD = 1'b1;
    #3;
    chk("L_fw_ldmem",  bus.FWD_B, 2);
    chk("L_fw_ldbub",  bus.EX_BUBBLE, 1);
    cyc();
    bus.ID_RS2_USE = 1'b0;
    #3;
    chk("L_fw_nouse",  bus.FWD_B, 0);
    cyc(); set_idle();

    // Taken branch: flush in RUN and FLUSH, second branch ignored.
    do_reset();
    bus.BR_TAKEN = 1'b1;
    #3;
    chk("L_br_flush1", bus.ID_FLUSH, 1);
    chk("L_br_bub1",   bus.EX_BUBBLE, 1);
    cyc(); #3;
    chk("L_br_state",  bus.STATE, 4);
    chk("L_br_flush2", bus.ID_FLUSH, 1);
    chk("L_br_bub2",   bus.EX_BUBBLE, 0);
    cyc(); bus.BR_TAKEN = 1'b0; #3;
    chk("L_br_run",    bus.STATE, 1);
    chk("L_br_flush3", bus.ID_FLUSH, 0);

    // DMEM busy 4 cycles with a concurrent load-use hazard.
    do_reset();
    set_load_use_rs1_3();
    bus.DMEM_BUSY = 1'b1;
    #3;
    chk("L_mw_ifen",   bus.IF_EN, 0);
    chk("L_mw_bub0",   bus.EX_BUBBLE, 0);
    repeat (3) begin
      cyc(); #3;
      chk("L_mw_bub",  bus.EX_BUBBLE, 0);
    end
    cyc(); bus.DMEM_BUSY = 1'b0; #3;
    chk("L_mw_last",   bus.STATE, 3);
    cyc(); #3;
    chk("L_mw_run",    bus.STATE, 1);
    chk("L_mw_cnt",    bus.STALL_CNT, 5);
    chk("L_mw_haz",    bus.EX_BUBBLE, 1);
    cyc(); set_idle(); #3;
    chk("L_mw_ld",     bus.STATE, 2);

    // Asynchronous reset during MEMWAIT.
    do_reset();
    bus.DMEM_BUSY = 1'b1;
    cyc();
    #2;
    bus.ID_VALID = 1'b1; bus.ID_RS1 = 5'd9; bus.ID_RS1_USE = 1'b1;
    bus.EX_RD = 5'd9; bus.EX_WE = 1'b1;
    RSTN = 1'b0;
    #1;
    chk("L_ar_state",  bus.STATE, 0);
    chk("L_ar_cnt",    bus.STALL_CNT, 0);
    chk("L_ar_ifen",   bus.IF_EN, 0);
    chk("L_ar_ireq",   bus.IREQ, 0);
    chk("L_ar_fwda",   bus.FWD_A, 0);
    cyc(); cyc();
    set_idle();
    RSTN = 1'b1;
    #3;
    chk("L_ar_idle",   bus.STATE, 0);
    cyc(); #3;
    chk("L_ar_run",    bus.STATE, 1);

    // Counter saturation: run up to 0xFFFE, then 3 more stall cycles.
    do_reset();
    bus.DMEM_BUSY = 1'b1;
    repeat (65534) cyc();
    #3;
    chk("L_sat_fffe",  bus.STALL_CNT, 32'hFFFE);
    repeat (3) cyc();
    #3;
    chk("L_sat_ffff",  bus.STALL_CNT, 32'hFFFF);
    cyc(); set_idle();
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
